// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler: round-robin arbiter that hands a single registered
// output channel to one requester at a time for a whole burst. A grant ends
// on req_last or after MAX_BURST beats, whichever comes first.
module rr_burst_scheduler #(
    parameter int TOTAL     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TOTAL-1:0]           req_valid,
    input  logic [TOTAL*WIDTH-1:0]     req_data,
    input  logic [TOTAL-1:0]           req_last,
    output logic [TOTAL-1:0]           req_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    output logic [$clog2(TOTAL)-1:0]   out_src,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int SRC_W = $clog2(TOTAL);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;

    logic [WIDTH-1:0]   data_arr [TOTAL];
    logic               out_free;
    logic               grant_open;
    logic               accept;
    logic               beat_last;
    logic               search_hit;
    logic [SRC_W-1:0]   search_sel;
    logic [SRC_W-1:0]   cand;

    // Unpack the flat payload bus so the granted lane can be picked by index.
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[WIDTH*gi +: WIDTH];
    end

    // The output register can take a new beat when it is empty or draining now.
    assign out_free   = ~out_valid_q | out_ready;
    assign grant_open = (state_q == GRANT) & out_free;
    assign accept     = grant_open & req_valid[ptr_q];
    // A beat closes the grant on a real last or when the burst cap is reached.
    assign beat_last  = req_last[ptr_q] | (beat_cnt_q == 8'(MAX_BURST - 1));

    // Only the granted requester ever sees ready, and only while in GRANT.
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_ready
        assign req_ready[gi] = grant_open & (ptr_q == SRC_W'(gi));
    end

    // Round-robin search: first valid requester strictly after the last grant.
    always_comb begin
        search_hit = 1'b0;
        search_sel = '0;
        cand       = '0;
        for (int k = 1; k <= TOTAL; k++) begin
            cand = SRC_W'((int'(ptr_q) + k) % TOTAL);
            if (!search_hit && req_valid[cand]) begin
                search_hit = 1'b1;
                search_sel = cand;
            end
        end
    end

    // Next-state logic for the grant FSM and the registered output stage.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        case (state_q)
            IDLE: begin
                if (search_hit) begin
                    state_d    = GRANT;
                    ptr_d      = search_sel;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = data_arr[ptr_q];
            out_last_d  = beat_last;
            out_src_d   = ptr_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any beat held for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= SRC_W'(TOTAL - 1);
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler: per-requester beat lists feed the
// inputs, expected output beats go into a scoreboard queue as each scenario
// is set up, and a consumer-side monitor pops and compares every handshake.
module tb_rr_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  bdata [4][16];
    logic        blast [4][16];
    int          head [4];
    int          tail [4];
    logic [3:0]  hs;
    logic [10:0] exp_q [$];
    logic [10:0] exp_w;

    rr_burst_scheduler #(.TOTAL(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Consumer-side scoreboard: every accepted output beat must match the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_beat observed=%h expected=none", {out_src, out_last, out_data});
            end else begin
                exp_w = exp_q.pop_front();
                assert ({out_src, out_last, out_data} === exp_w) else begin
                    errors++;
                    $error("FAIL beat observed=%h expected=%h", {out_src, out_last, out_data}, exp_w);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic add_beat(input int r, input logic [7:0] d, input logic l);
        bdata[r][tail[r]] = d;
        blast[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic expect_beat(input logic [1:0] s, input logic [7:0] d, input logic l);
        exp_q.push_back({s, l, d});
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = bdata[i][head[i]];
                req_last[i]        = blast[i][head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) p = 1'b1;
        end
        return p;
    endfunction

    // One clock: note handshakes before the edge, advance requesters after it.
    task automatic tick();
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) head[i]++;
        end
        drive();
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_q.delete();
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        #2;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_req_ready", 16'(req_ready), 16'd0);
        chk("rst_busy",      16'(busy),      16'd0);
        chk("rst_out_data",  16'(out_data),  16'd0);
        chk("rst_out_src",   16'(out_src),   16'd0);
        chk("rst_out_last",  16'(out_last),  16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_ov(input int bound, input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 16'(out_valid), 16'd1);
    endtask

    task automatic drain(input int bound, input string tag);
        int n = 0;
        while ((pending() || exp_q.size() != 0 || out_valid === 1'b1 || busy === 1'b1) && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        hs        = '0;
        #1;
        do_reset();

        // Single requester, three-beat burst with latency checks.
        add_beat(2, 8'h11, 1'b0);
        add_beat(2, 8'h22, 1'b0);
        add_beat(2, 8'h33, 1'b1);
        expect_beat(2'd2, 8'h11, 1'b0);
        expect_beat(2'd2, 8'h22, 1'b0);
        expect_beat(2'd2, 8'h33, 1'b1);
        drive();
        #1;
        chk("t1_ready_idle", 16'(req_ready), 16'd0);
        chk("t1_busy_idle",  16'(busy),      16'd0);
        tick();
        chk("t1_ready_grant", 16'(req_ready), 16'b0100);
        chk("t1_busy_grant",  16'(busy),      16'd1);
        chk("t1_ov_n1",       16'(out_valid), 16'd0);
        tick();
        chk("t1_ov_n2",  16'(out_valid), 16'd1);
        chk("t1_data0",  16'(out_data),  16'h11);
        chk("t1_last0",  16'(out_last),  16'd0);
        tick();
        chk("t1_data1",  16'(out_data),  16'h22);
        tick();
        chk("t1_data2",  16'(out_data),  16'h33);
        chk("t1_last2",  16'(out_last),  16'd1);
        chk("t1_src2",   16'(out_src),   16'd2);
        chk("t1_busy_end", 16'(busy),    16'd0);
        drain(20, "t1_drain");

        // Round-robin fairness with one-beat bursts from every requester.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            add_beat(r, 8'(8'hA0 + r), 1'b1);
            add_beat(r, 8'(8'hB0 + r), 1'b1);
        end
        for (int r = 0; r < 4; r++) expect_beat(2'(r), 8'(8'hA0 + r), 1'b1);
        for (int r = 0; r < 4; r++) expect_beat(2'(r), 8'(8'hB0 + r), 1'b1);
        drive();
        wait_ov(10, "t2_first_ov");
        for (int k = 0; k < 6; k++) begin
            chk("t2_gap_pattern", 16'(out_valid), (k % 2 == 0) ? 16'd1 : 16'd0);
            tick();
        end
        drain(60, "t2_drain");

        // Forced break after MAX_BURST beats, single requester.
        do_reset();
        for (int b = 1; b <= 6; b++) add_beat(1, 8'(b), (b == 6));
        for (int b = 1; b <= 6; b++) expect_beat(2'd1, 8'(b), (b == 4) || (b == 6));
        drive();
        drain(60, "t3a_drain");

        // Forced break with requester 3 pending: it is served between beats 4 and 5.
        do_reset();
        for (int b = 1; b <= 6; b++) add_beat(1, 8'(b), (b == 6));
        add_beat(3, 8'h31, 1'b0);
        add_beat(3, 8'h32, 1'b1);
        for (int b = 1; b <= 4; b++) expect_beat(2'd1, 8'(b), (b == 4));
        expect_beat(2'd3, 8'h31, 1'b0);
        expect_beat(2'd3, 8'h32, 1'b1);
        expect_beat(2'd1, 8'h05, 1'b0);
        expect_beat(2'd1, 8'h06, 1'b1);
        drive();
        drain(80, "t3b_drain");

        // Backpressure: consumer stalls for five cycles with a beat held.
        do_reset();
        for (int b = 1; b <= 4; b++) add_beat(0, 8'(8'h40 + b), (b == 4));
        for (int b = 1; b <= 4; b++) expect_beat(2'd0, 8'(8'h40 + b), (b == 4));
        drive();
        wait_ov(10, "t4_first_ov");
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_ready_low", 16'(req_ready), 16'd0);
            chk("t4_data_hold", 16'(out_data),  16'h41);
            chk("t4_ov_hold",   16'(out_valid), 16'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t4_resume", 16'(req_ready), 16'b0001);
        drain(40, "t4_drain");

        // Mid-burst asynchronous reset, then first grant from the lowest index.
        do_reset();
        for (int b = 1; b <= 4; b++) add_beat(2, 8'(8'h50 + b), (b == 4));
        drive();
        wait_ov(10, "t5_first_ov");
        chk("t5_busy_before", 16'(busy), 16'd1);
        rst = 1'b1;
        #1;
        chk("t5_ov_async",    16'(out_valid), 16'd0);
        chk("t5_ready_async", 16'(req_ready), 16'd0);
        chk("t5_busy_async",  16'(busy),      16'd0);
        clear_reqs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        add_beat(3, 8'h61, 1'b1);
        add_beat(1, 8'h62, 1'b1);
        expect_beat(2'd1, 8'h62, 1'b1);
        expect_beat(2'd3, 8'h61, 1'b1);
        drive();
        #1;
        tick();
        chk("t5_first_grant", 16'(req_ready), 16'b0010);
        drain(30, "t5_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
